// File: rtl/cs_final_adder.sv
// cs_final_adder: two-stage pipelined carry-propagate adder that resolves a
// carry-save pair (S1, S2) into binary form {out_cout, out_sum} = S1 + S2.
// Stage 1 adds the low halves and registers the low-half carry; stage 2 adds
// the high halves with that carry. Valid/ready handshake on both sides with
// a combinational out_ready -> in_ready path, so full throughput is kept.
module cs_final_adder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] S1,
  input  logic [WIDTH-1:0] S2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
);

  localparam int H = WIDTH / 2;

  // Stage-1 registers: low-half sum and carry, untouched high halves.
  logic [H-1:0] lo_sum1_reg;
  logic         lo_carry1_reg;
  logic [H-1:0] hi_a1_reg;
  logic [H-1:0] hi_b1_reg;
  logic         v1_reg;

  // Stage-2 registers: drive the outputs directly.
  logic [H-1:0] hi_sum2_reg;
  logic [H-1:0] lo_sum2_reg;
  logic         cout2_reg;
  logic         v2_reg;

  // Pipeline control.
  logic adv1;
  logic adv2;
  logic in_hs;

  // Adder results feeding the stage registers (one extra bit for carry out).
  logic [H:0] lo_add_next;
  logic [H:0] hi_add_next;

  // A stage may load when it is empty or when the stage after it moves on.
  assign adv2     = !v2_reg || out_ready;
  assign adv1     = !v1_reg || adv2;
  assign in_ready = adv1;
  assign in_hs    = in_valid && adv1;

  assign lo_add_next = {1'b0, S1[H-1:0]} + {1'b0, S2[H-1:0]};
  assign hi_add_next = {1'b0, hi_a1_reg} + {1'b0, hi_b1_reg}
                     + {{H{1'b0}}, lo_carry1_reg};

  // Stage 1: capture the low-half addition and the raw high halves on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lo_sum1_reg   <= '0;
      lo_carry1_reg <= 1'b0;
      hi_a1_reg     <= '0;
      hi_b1_reg     <= '0;
      v1_reg        <= 1'b0;
    end else if (adv1) begin
      // Valid follows the input handshake; data is only taken on a real
      // transfer so idle operand wiggles never reach the registers.
      v1_reg <= in_valid;
      if (in_valid) begin
        lo_sum1_reg   <= lo_add_next[H-1:0];
        lo_carry1_reg <= lo_add_next[H];
        hi_a1_reg     <= S1[WIDTH-1:H];
        hi_b1_reg     <= S2[WIDTH-1:H];
      end
    end
  end

  // Stage 2: finish the high half using the low-half carry from stage 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_sum2_reg <= '0;
      lo_sum2_reg <= '0;
      cout2_reg   <= 1'b0;
      v2_reg      <= 1'b0;
    end else if (adv2) begin
      // Holding the data when stage 1 is empty keeps out_sum quiet on bubbles.
      v2_reg <= v1_reg;
      if (v1_reg) begin
        hi_sum2_reg <= hi_add_next[H-1:0];
        lo_sum2_reg <= lo_sum1_reg;
        cout2_reg   <= hi_add_next[H];
      end
    end
  end

  assign out_valid = v2_reg;
  assign out_sum   = {hi_sum2_reg, lo_sum2_reg};
  assign out_cout  = cout2_reg;

endmodule

// File: tb/tb_cs_final_adder.sv
// tb_cs_final_adder: directed and randomized checks for cs_final_adder.
// Inputs change 1 ns after the rising edge; handshakes are sampled on the
// falling edge; a queue of expected 33-bit sums tracks results in order.
module tb_cs_final_adder;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] s1 = '0;
  logic [WIDTH-1:0] s2 = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;

  int errors = 0;
  int checks = 0;
  int rcv = 0;
  int rcv0;
  int sent;

  logic [WIDTH:0] exp_q[$];
  logic [WIDTH:0] held;
  logic [WIDTH:0] e;
  logic           stall_prev = 1'b0;
  logic           last_in_hs = 1'b0;
  logic           last_out_hs = 1'b0;
  logic           smp_in_ready;
  logic           smp_out_valid;
  logic [WIDTH-1:0] smp_sum;

  always #5 clk = ~clk;

  cs_final_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .S1        (s1),
    .S2        (s2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: sample at the falling edge, score handshakes, then
  // advance to 1 ns past the next rising edge.
  task automatic tick();
    @(negedge clk);
    smp_in_ready  = in_ready;
    smp_out_valid = out_valid;
    smp_sum       = out_sum;
    // Only a completely full pipeline with a stalled sink blocks the input.
    check("in_ready", in_ready, !(exp_q.size() == 2 && !out_ready));
    if (exp_q.size() == 0) check("idle_valid", out_valid, 0);
    if (stall_prev) begin
      check("hold_valid", out_valid, 1);
      check("hold_data", {out_cout, out_sum}, held);
    end
    last_out_hs = out_valid && out_ready;
    if (last_out_hs) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", out_valid, 0);
      end else begin
        e = exp_q.pop_front();
        check("result", {out_cout, out_sum}, e);
        rcv++;
        $display("rx %0d: cout=%0d sum=0x%08h", rcv, out_cout, out_sum);
      end
    end
    stall_prev  = out_valid && !out_ready;
    held        = {out_cout, out_sum};
    last_in_hs  = in_valid && in_ready;
    if (last_in_hs) exp_q.push_back({1'b0, s1} + {1'b0, s2});
    @(posedge clk);
    #1;
  endtask

  // Single pair through an empty pipe: checks the two-cycle latency and the
  // hand-computed sum/carry.
  task automatic single(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] es, input logic ec);
    in_valid  = 1'b1;
    s1        = a;
    s2        = b;
    out_ready = 1'b1;
    tick();
    check("single_accept", last_in_hs, 1);
    in_valid = 1'b0;
    s1       = '1;
    s2       = '1;
    check("lat_not_yet", out_valid, 0);
    tick();
    check("lat_valid", out_valid, 1);
    check("lat_sum", out_sum, es);
    check("lat_cout", out_cout, ec);
    tick();
  endtask

  initial begin
    // Reset state, asserted between edges.
    #1 rst = 1'b1;
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_out_cout", out_cout, 0);
    check("rst_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("post_rst_in_ready", in_ready, 1);

    // Directed single pairs.
    single(32'h0000_FFFF, 32'h0000_0001, 32'h0001_0000, 1'b0);
    single(32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1);
    single(32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1);
    single(32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0);
    single(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    single(32'hFFFF_0000, 32'h0001_0000, 32'h0000_0000, 1'b1);

    // Backpressure: pairs (k, 2k), sink stalled for 4 cycles after the first result.
    begin
      int k;
      k = 1;
      rcv0 = rcv;
      for (int c = 0; c < 40 && (rcv - rcv0) < 5; c++) begin
        out_ready = !(c >= 2 && c < 6);
        in_valid  = (k <= 5);
        s1        = 32'(k);
        s2        = 32'(2 * k);
        tick();
        if (c >= 2 && c < 6) begin
          check("bp_in_ready_low", smp_in_ready, 0);
          check("bp_valid_held", smp_out_valid, 1);
          check("bp_sum_held", smp_sum, 3);
        end
        if (last_in_hs) k++;
      end
      check("bp_count", rcv - rcv0, 5);
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end

    // Full throughput: 100 random pairs, one result per cycle after fill.
    rcv0 = rcv;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      s1 = $urandom;
      s2 = $urandom;
      tick();
      check("tp_accept", last_in_hs, 1);
      if (i >= 2) check("tp_rate", last_out_hs, 1);
    end
    in_valid = 1'b0;
    repeat (2) tick();
    check("tp_count", rcv - rcv0, 100);

    // Reset mid-flight with two pairs held in the pipe.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    s1 = 32'd10; s2 = 32'd20;
    tick();
    s1 = 32'd30; s2 = 32'd40;
    tick();
    in_valid = 1'b0;
    check("mid_valid_before", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_out_valid", out_valid, 0);
    check("mid_out_sum", out_sum, 0);
    check("mid_out_cout", out_cout, 0);
    check("mid_in_ready", in_ready, 1);
    exp_q.delete();
    stall_prev = 1'b0;
    @(posedge clk);
    #1;
    check("mid_hold_valid", out_valid, 0);
    rst = 1'b0;
    check("mid_release_in_ready", in_ready, 1);
    out_ready = 1'b1;
    repeat (3) tick();
    single(32'h0000_0003, 32'h0000_0004, 32'h0000_0007, 1'b0);

    // Bubbles: random valid/ready on both sides for 1000 accepted pairs.
    sent = 0;
    for (int c = 0; c < 10000 && sent < 1000; c++) begin
      in_valid  = $urandom_range(0, 1);
      s1        = $urandom;
      s2        = $urandom;
      out_ready = $urandom_range(0, 1);
      tick();
      if (last_in_hs) sent++;
    end
    check("bub_sent", sent, 1000);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10 && exp_q.size() > 0; c++) tick();
    check("bub_drain", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cs_final_adder.md
CS_FINAL_ADDER -- requirements
Module: cs_final_adder

Interface
REQ-001 Parameter: WIDTH, 32, operand width in bits; SHALL be even and at least 4.
REQ-002 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous and active-high.
REQ-004 Port: in_valid  input  1  an upstream carry-save pair is presented.
REQ-005 Port: in_ready  output  1  block accepts the presented pair this cycle.
REQ-006 Port: S1  input  WIDTH  sum vector from the 4:2 compression stage.
REQ-007 Port: S2  input  WIDTH  carry vector from the 4:2 compression stage, already weight-aligned with S1.
REQ-008 Port: out_valid  output  1  out_sum/out_cout hold a valid result.
REQ-009 Port: out_ready  input  1  downstream accepts the result this cycle.
REQ-010 Port: out_sum  output  WIDTH  (S1 + S2) mod 2^WIDTH.
REQ-011 Port: out_cout  output  1  bit WIDTH of S1 + S2.

Function
REQ-012 The block SHALL resolve one carry-save pair into binary form as {out_cout, out_sum} = S1 + S2, with the full WIDTH+1-bit result and no truncation other than that stated.
REQ-013 Stage 1 SHALL add the low halves S1[H-1:0] + S2[H-1:0] (H = WIDTH/2), and register the H-bit low sum, the low-half carry, the unmodified high halves of S1 and S2, and a valid bit v1.
REQ-014 Stage 2 SHALL add the registered high halves plus the registered low-half carry, and register the H-bit high sum, the low sum, out_cout, and a valid bit v2.
REQ-015 out_valid SHALL equal v2; out_sum SHALL be {high sum, low sum}; all outputs SHALL be driven directly from stage-2 registers.
REQ-016 Latency: a pair accepted in cycle N SHALL appear on the outputs in cycle N+2 when out_ready is held high.
REQ-017 Throughput: one pair per cycle SHALL be sustained while out_ready is high.
REQ-018 Advance rules: adv2 = !v2 | out_ready; adv1 = !v1 | adv2; in_ready = adv1; combinational out_ready-to-in_ready path permitted.
REQ-019 Transfer: input handshake when in_valid & in_ready; output handshake when out_valid & out_ready.
REQ-020 When a stage does not advance, its data and valid registers SHALL hold their values unchanged; out_sum/out_cout SHALL stay stable while out_valid=1 and out_ready=0.
REQ-021 When stage 1 advances with no input handshake, v1 SHALL clear; when stage 2 advances with v1=0, v2 SHALL clear.
REQ-022 Simultaneous input and output handshake with both stages full SHALL shift both stages with no loss or duplication.
REQ-023 Order SHALL be preserved: results leave in acceptance order, at most two pairs in flight.
REQ-024 S1/S2 SHALL be ignored when in_valid=0 or in_ready=0.

Reset
REQ-025 While rst=1: v1=0, v2=0, out_valid=0, out_sum=0, out_cout=0, all data registers 0, regardless of clk.
REQ-026 Reset asserted mid-operation SHALL discard all in-flight pairs; no result for them SHALL appear after release.
REQ-027 in_ready SHALL be 1 during and immediately after reset (both stages empty).
REQ-028 First input handshake possible on the first rising clk edge after rst deasserts.

Verification
REQ-029 Basic: WIDTH=32, S1=0x0000_FFFF, S2=0x0000_0001, out_ready=1 -> two cycles later out_valid=1, out_sum=0x0001_0000, out_cout=0 (low-half carry crosses stages).
REQ-030 Overflow: S1=0xFFFF_FFFF, S2=0x0000_0001 -> out_sum=0x0000_0000, out_cout=1; S1=S2=0x8000_0000 -> out_sum=0, out_cout=1.
REQ-031 Backpressure: stream 5 pairs (k, 2k) for k=1..5, out_ready=0 for 4 cycles after first result -> in_ready falls after 2 pairs held, out_sum stays 3 while stalled, then results 3,6,9,12,15 in order, none lost.
REQ-032 Full throughput: in_valid=1, out_ready=1 for 100 random pairs -> 100 results, each equal to 33-bit S1+S2, one per cycle after 2-cycle fill.
REQ-033 Reset mid-flight: accept 2 pairs, assert rst asynchronously between edges -> out_valid drops to 0 immediately, out_sum=0; after release, no stale result emitted, in_ready=1.
REQ-034 Bubbles: random in_valid and out_ready toggling, 1000 pairs -> scoreboard matches in order, outputs stable whenever out_valid=1 and out_ready=0.
